// File: rtl/store_narrow_unit_pkg.sv
// Shared types for the store narrowing path: size encodings, FSM states and
// the alignment rule used to reject illegal requests.
package store_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        ERR
    } st_state_t;

    function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] addr_lo);
        return (size == SZ_ILL) ||
               ((size == SZ_HALF) && addr_lo[0]) ||
               ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/store_narrow_unit_if.sv
// Request/response bus between the MEM stage, the store unit and the
// word-only data memory.
interface store_narrow_unit_if;

    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic [1:0]  st_size;
    logic        st_done;
    logic        st_err;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic [31:0] mem_rdata;
    logic        mem_wr;
    logic [31:0] mem_wdata;

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_rdata,
        input  st_ready, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_rdata,
        output st_ready, st_done, st_err, mem_addr, mem_rd, mem_wr, mem_wdata
    );

endinterface

// File: rtl/store_narrow_unit_lane_merge.sv
// Combinational lane merge: drops the low byte/halfword of st_data into the
// addressed lane of an existing memory word, leaving other bits untouched.
module store_lane_merge
    import store_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [31:0] old_word,
    input  logic [31:0] st_data,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] merged
);

    logic [4:0]  shift;
    logic [31:0] mask;

    always_comb begin
        shift  = '0;
        mask   = '0;
        merged = old_word;
        case (size)
            SZ_BYTE: begin
                // Big-endian lane k sits at bit 8*(3-k); 3-k is ~k on two bits.
                shift  = BIG_ENDIAN ? {~addr_lo, 3'b000} : {addr_lo, 3'b000};
                mask   = 32'h0000_00FF << shift;
                merged = (old_word & ~mask) | ((st_data & 32'h0000_00FF) << shift);
            end
            SZ_HALF: begin
                shift  = BIG_ENDIAN ? {~addr_lo[1], 4'b0000} : {addr_lo[1], 4'b0000};
                mask   = 32'h0000_FFFF << shift;
                merged = (old_word & ~mask) | ((st_data & 32'h0000_FFFF) << shift);
            end
            SZ_WORD: merged = st_data;
            default: merged = old_word;
        endcase
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: word stores write directly, byte/half stores do a
// read-modify-write against a memory without byte enables.
module store_narrow_unit
    import store_pkg::*;
#(
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          BIG_ENDIAN   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    store_narrow_unit_if.slave bus
);

    localparam int unsigned      CNT_W    = $clog2(READ_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

    st_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      data_q, data_d;
    logic [1:0]       size_q, size_d;
    logic [1:0]       addr_lo_q, addr_lo_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic             mem_rd_q, mem_rd_d;
    logic             mem_wr_q, mem_wr_d;
    logic             st_done_q, st_done_d;
    logic             st_err_q, st_err_d;
    logic             accept;
    logic [31:0]      merged;

    assign bus.st_ready = (state_q == IDLE) && !reset;
    assign accept       = bus.st_valid && bus.st_ready;

    store_lane_merge #(.BIG_ENDIAN(BIG_ENDIAN)) u_merge (
        .old_word (bus.mem_rdata),
        .st_data  (data_q),
        .size     (size_q),
        .addr_lo  (addr_lo_q),
        .merged   (merged)
    );

    // Outputs are decoded from the next state so each strobe lines up with
    // the cycle its state is occupied.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        data_d      = data_q;
        size_d      = size_q;
        addr_lo_d   = addr_lo_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_rd_d    = 1'b0;
        mem_wr_d    = 1'b0;
        st_done_d   = 1'b0;
        st_err_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    data_d     = bus.st_data;
                    size_d     = bus.st_size;
                    addr_lo_d  = bus.st_addr[1:0];
                    mem_addr_d = {bus.st_addr[31:2], 2'b00};
                    if (is_illegal(bus.st_size, bus.st_addr[1:0])) begin
                        state_d   = ERR;
                        st_err_d  = 1'b1;
                        st_done_d = 1'b1;
                    end else if (bus.st_size == SZ_WORD) begin
                        state_d     = WRITE;
                        mem_wdata_d = bus.st_data;
                        mem_wr_d    = 1'b1;
                        st_done_d   = 1'b1;
                    end else begin
                        state_d  = READ;
                        mem_rd_d = 1'b1;
                    end
                end
            end
            READ: begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d     = WRITE;
                    mem_wdata_d = merged;
                    mem_wr_d    = 1'b1;
                    st_done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE:   state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            data_q      <= '0;
            size_q      <= '0;
            addr_lo_q   <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            st_done_q   <= 1'b0;
            st_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
            size_q      <= size_d;
            addr_lo_q   <= addr_lo_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_rd_q    <= mem_rd_d;
            mem_wr_q    <= mem_wr_d;
            st_done_q   <= st_done_d;
            st_err_q    <= st_err_d;
        end
    end

    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.st_done   = st_done_q;
    assign bus.st_err    = st_err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: three instances (L=1 BE, L=1 LE, L=3 BE) share
// a latency-accurate word memory model and a byte-array reference model.
module tb_store_narrow_unit;

    localparam int unsigned LATS [3] = '{1, 1, 3};
    localparam bit          BES  [3] = '{1'b1, 1'b0, 1'b1};

    logic        clk;
    logic        rst     [3];
    logic        valid   [3];
    logic [31:0] addr_i  [3];
    logic [31:0] data_i  [3];
    logic [1:0]  size_i  [3];
    logic        rdy     [3];
    logic        done_o  [3];
    logic        err_o   [3];
    logic        rd_o    [3];
    logic        wr_o    [3];
    logic [31:0] maddr   [3];
    logic [31:0] wdata_o [3];

    logic [31:0] mem     [3][1024];
    int          age     [3];
    int          rd_cnt  [3];
    int          wr_cnt  [3];
    int          done_cnt[3];

    int checks;
    int errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        store_narrow_unit_if bus ();
        store_narrow_unit #(.READ_LATENCY(LATS[g]), .BIG_ENDIAN(BES[g])) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus.slave)
        );
        assign bus.st_valid  = valid[g];
        assign bus.st_addr   = addr_i[g];
        assign bus.st_data   = data_i[g];
        assign bus.st_size   = size_i[g];
        // Read data is correct only in the final WAIT cycle, inverted otherwise.
        assign bus.mem_rdata = (age[g] == int'(LATS[g]) + 1) ? mem[g][bus.mem_addr[11:2]]
                                                             : ~mem[g][bus.mem_addr[11:2]];
        assign rdy[g]     = bus.st_ready;
        assign done_o[g]  = bus.st_done;
        assign err_o[g]   = bus.st_err;
        assign rd_o[g]    = bus.mem_rd;
        assign wr_o[g]    = bus.mem_wr;
        assign maddr[g]   = bus.mem_addr;
        assign wdata_o[g] = bus.mem_wdata;
    end

    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst[d]) age[d] <= 0;
            else if (rd_o[d]) begin
                rd_cnt[d] <= rd_cnt[d] + 1;
                age[d]    <= 1;
            end else if (age[d] != 0 && age[d] < 1000) age[d] <= age[d] + 1;
            if (wr_o[d]) begin
                wr_cnt[d] <= wr_cnt[d] + 1;
                mem[d][maddr[d][11:2]] <= wdata_o[d];
            end
            if (done_o[d]) done_cnt[d] <= done_cnt[d] + 1;
        end
    end

    function automatic bit ref_illegal(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
    endfunction

    // Word viewed as four bytes in memory order; the store overwrites bytes at its offset.
    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [31:0] dt,
                                              input logic [1:0] sz, input logic [31:0] a,
                                              input bit be);
        logic [7:0]  b [4];
        logic [31:0] w;
        int          off;
        off = int'(a % 4);
        for (int k = 0; k < 4; k++) b[k] = 8'(old >> (8 * (be ? 3 - k : k)));
        if (sz == 2'd2) return dt;
        if (sz == 2'd0) b[off] = dt[7:0];
        else begin
            b[off]     = be ? dt[15:8] : dt[7:0];
            b[off + 1] = be ? dt[7:0]  : dt[15:8];
        end
        w = '0;
        for (int k = 0; k < 4; k++) w = w | (32'(b[k]) << (8 * (be ? 3 - k : k)));
        return w;
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input int d, input logic [31:0] a, input logic [31:0] dt, input logic [1:0] sz);
        valid[d] = 1'b1; addr_i[d] = a; data_i[d] = dt; size_i[d] = sz;
        tick();
        valid[d] = 1'b0; addr_i[d] = $urandom; data_i[d] = $urandom; size_i[d] = 2'($urandom);
    endtask

    task automatic test_reset(input int d);
        rst[d] = 1'b1;
        tick();
        checks++;
        if ({rdy[d], rd_o[d], wr_o[d], done_o[d], err_o[d]} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes dut%0d: got %b, expected 00000", d,
                               {rdy[d], rd_o[d], wr_o[d], done_o[d], err_o[d]});
        end
        checks++;
        if ({maddr[d], wdata_o[d]} !== 64'h0) begin
            errors++; $display("FAIL reset_regs dut%0d: got %h, expected 0", d, {maddr[d], wdata_o[d]});
        end
        rst[d] = 1'b0;
        tick();
        checks++;
        if (rdy[d] !== 1'b1) begin
            errors++; $display("FAIL reset_ready dut%0d: got %b, expected 1", d, rdy[d]);
        end
    endtask

    task automatic test_word(input int d, input logic [31:0] a, input logic [31:0] dt);
        int wc, rc;
        wc = wr_cnt[d]; rc = rd_cnt[d];
        issue(d, a, dt, 2'd2);
        checks++;
        if ({wr_o[d], done_o[d], err_o[d], rd_o[d], rdy[d]} !== 5'b11000) begin
            errors++; $display("FAIL word_t1_strobes dut%0d: got %b, expected 11000", d,
                               {wr_o[d], done_o[d], err_o[d], rd_o[d], rdy[d]});
        end
        checks++;
        if (maddr[d] !== (a & ~32'h3) || wdata_o[d] !== dt) begin
            errors++; $display("FAIL word_t1_bus dut%0d: got %h/%h, expected %h/%h", d,
                               maddr[d], wdata_o[d], a & ~32'h3, dt);
        end
        tick();
        checks++;
        if ({rdy[d], wr_o[d], done_o[d]} !== 3'b100 || wr_cnt[d] - wc != 1 || rd_cnt[d] != rc) begin
            errors++; $display("FAIL word_t2 dut%0d: got rdy/wr/done %b wr+%0d rd+%0d, expected 100 wr+1 rd+0",
                               d, {rdy[d], wr_o[d], done_o[d]}, wr_cnt[d] - wc, rd_cnt[d] - rc);
        end
    endtask

    task automatic test_narrow(input int d, input logic [31:0] a, input logic [31:0] dt,
                               input logic [1:0] sz, input logic [31:0] old);
        logic [31:0] exp;
        int wc, rc;
        mem[d][a[11:2]] = old;
        exp = ref_store(old, dt, sz, a, BES[d]);
        wc = wr_cnt[d]; rc = rd_cnt[d];
        issue(d, a, dt, sz);
        checks++;
        if ({rd_o[d], wr_o[d], rdy[d]} !== 3'b100 || maddr[d] !== (a & ~32'h3)) begin
            errors++; $display("FAIL narrow_read dut%0d: got rd/wr/rdy %b addr %h, expected 100 addr %h",
                               d, {rd_o[d], wr_o[d], rdy[d]}, maddr[d], a & ~32'h3);
        end
        for (int i = 0; i < int'(LATS[d]); i++) begin
            tick();
            checks++;
            if ({rd_o[d], wr_o[d], done_o[d], rdy[d]} !== 4'b0) begin
                errors++; $display("FAIL narrow_wait dut%0d cyc%0d: got %b, expected 0000", d, i,
                                   {rd_o[d], wr_o[d], done_o[d], rdy[d]});
            end
        end
        tick();
        checks++;
        if ({wr_o[d], done_o[d], err_o[d], rdy[d]} !== 4'b1100 || wdata_o[d] !== exp) begin
            errors++; $display("FAIL narrow_write dut%0d a=%h: got strobes %b data %h, expected 1100 data %h",
                               d, a, {wr_o[d], done_o[d], err_o[d], rdy[d]}, wdata_o[d], exp);
        end
        tick();
        checks++;
        if (rdy[d] !== 1'b1 || wr_cnt[d] - wc != 1 || rd_cnt[d] - rc != 1 || mem[d][a[11:2]] !== exp) begin
            errors++; $display("FAIL narrow_end dut%0d: got rdy %b wr+%0d rd+%0d mem %h, expected 1 +1 +1 %h",
                               d, rdy[d], wr_cnt[d] - wc, rd_cnt[d] - rc, mem[d][a[11:2]], exp);
        end
    endtask

    task automatic test_error(input int d, input logic [31:0] a, input logic [1:0] sz);
        logic [31:0] prev;
        int wc, rc;
        prev = wdata_o[d]; wc = wr_cnt[d]; rc = rd_cnt[d];
        issue(d, a, $urandom, sz);
        checks++;
        if ({err_o[d], done_o[d], rd_o[d], wr_o[d]} !== 4'b1100 || wdata_o[d] !== prev) begin
            errors++; $display("FAIL error_t1 dut%0d a=%h sz=%0d: got %b data %h, expected 1100 data %h",
                               d, a, sz, {err_o[d], done_o[d], rd_o[d], wr_o[d]}, wdata_o[d], prev);
        end
        tick();
        checks++;
        if ({rdy[d], err_o[d], done_o[d]} !== 3'b100 || wr_cnt[d] != wc || rd_cnt[d] != rc) begin
            errors++; $display("FAIL error_t2 dut%0d: got %b wr+%0d rd+%0d, expected 100 +0 +0", d,
                               {rdy[d], err_o[d], done_o[d]}, wr_cnt[d] - wc, rd_cnt[d] - rc);
        end
    endtask

    task automatic test_reset_mid(input int d);
        int wc;
        mem[d][10'h0D1] = $urandom;
        wc = wr_cnt[d];
        issue(d, 32'h344, $urandom, 2'd0);
        tick();
        rst[d] = 1'b1;
        #1;
        checks++;
        if ({rdy[d], rd_o[d], wr_o[d], done_o[d], err_o[d]} !== 5'b0 || {maddr[d], wdata_o[d]} !== 64'h0) begin
            errors++; $display("FAIL midreset_outputs dut%0d: got %b %h %h, expected 00000 0 0", d,
                               {rdy[d], rd_o[d], wr_o[d], done_o[d], err_o[d]}, maddr[d], wdata_o[d]);
        end
        tick(); tick();
        rst[d] = 1'b0;
        tick(); tick();
        checks++;
        if (wr_cnt[d] != wc || rdy[d] !== 1'b1) begin
            errors++; $display("FAIL midreset_nowrite dut%0d: got wr+%0d rdy %b, expected +0 1", d,
                               wr_cnt[d] - wc, rdy[d]);
        end
        test_word(d, 32'h348, $urandom);
    endtask

    task automatic test_back_to_back(input int d);
        logic [31:0] ra [3];
        logic [31:0] rdt[3];
        logic [1:0]  rsz[3];
        logic [31:0] exp[3];
        int acc[3];
        int idx, cyc, wc, dc;
        ra = '{32'h400, 32'h405, 32'h408};
        rsz = '{2'd2, 2'd0, 2'd2};
        for (int i = 0; i < 3; i++) rdt[i] = $urandom;
        mem[d][10'h101] = $urandom;
        exp[0] = rdt[0];
        exp[1] = ref_store(mem[d][10'h101], rdt[1], 2'd0, ra[1], BES[d]);
        exp[2] = rdt[2];
        wc = wr_cnt[d]; dc = done_cnt[d]; idx = 0; cyc = 0;
        while (idx < 3 && cyc < 40) begin
            valid[d] = 1'b1;
            if (rdy[d] === 1'b1) begin
                addr_i[d] = ra[idx]; data_i[d] = rdt[idx]; size_i[d] = rsz[idx];
                acc[idx] = cyc; idx++;
            end else begin
                addr_i[d] = $urandom; data_i[d] = $urandom; size_i[d] = 2'($urandom);
            end
            tick();
            cyc++;
        end
        valid[d] = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++;
        if (idx != 3 || acc[1] - acc[0] != 2 || acc[2] - acc[1] != 3 + int'(LATS[d])) begin
            errors++; $display("FAIL b2b_accepts dut%0d: got n=%0d gaps %0d,%0d, expected 3 gaps 2,%0d", d,
                               idx, acc[1] - acc[0], acc[2] - acc[1], 3 + int'(LATS[d]));
        end
        checks++;
        if (wr_cnt[d] - wc != 3 || done_cnt[d] - dc != 3) begin
            errors++; $display("FAIL b2b_counts dut%0d: got wr+%0d done+%0d, expected +3 +3", d,
                               wr_cnt[d] - wc, done_cnt[d] - dc);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[d][ra[i][11:2]] !== exp[i]) begin
                errors++; $display("FAIL b2b_mem%0d dut%0d: got %h, expected %h", i, d, mem[d][ra[i][11:2]], exp[i]);
            end
        end
    endtask

    task automatic test_random(input int n);
        int d;
        logic [1:0]  sz;
        logic [31:0] a;
        for (int i = 0; i < n; i++) begin
            d  = int'($urandom_range(0, 2));
            sz = 2'($urandom_range(0, 3));
            a  = 32'($urandom_range(0, 4095));
            if (ref_illegal(sz, a)) test_error(d, a, sz);
            else if (sz == 2'd2)    test_word(d, a, $urandom);
            else                    test_narrow(d, a, $urandom, sz, $urandom);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; valid[d] = 1'b0; addr_i[d] = '0; data_i[d] = '0; size_i[d] = '0;
            age[d] = 0; rd_cnt[d] = 0; wr_cnt[d] = 0; done_cnt[d] = 0;
            for (int w = 0; w < 1024; w++) mem[d][w] = '0;
        end
        tick(); tick();
        for (int d = 0; d < 3; d++) test_reset(d);

        test_word(0, 32'h100, 32'hDEADBEEF);
        test_narrow(0, 32'h103, 32'h0000_00AA, 2'd0, 32'h1122_3344);
        test_narrow(1, 32'h103, 32'h0000_00AA, 2'd0, 32'h1122_3344);
        test_narrow(2, 32'h202, 32'h1234_CAFE, 2'd1, 32'hFFFF_FFFF);
        test_narrow(1, 32'h202, 32'h1234_CAFE, 2'd1, 32'h0000_0000);
        test_error(0, 32'h101, 2'd1);
        test_error(0, 32'h102, 2'd2);
        test_error(0, 32'h100, 2'd3);
        test_reset_mid(2);
        for (int d = 0; d < 3; d++) test_back_to_back(d);
        test_random(40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_narrow_unit.md
# store_narrow_unit

Store-side narrowing unit for the MEM stage: takes a 32-bit register value plus a store size (byte/halfword/word) and writes it into a word-only data memory. It is the reverse of immediate/load sign extension: it narrows 32-bit data into a byte lane of a memory word. Because the data memory has no byte enables, sub-word stores use a read-modify-write sequence. The pipeline stalls on `st_ready` low.

## Interface
- `READ_LATENCY`, default 1: cycles from `mem_rd` assertion to valid `mem_rdata` (≥1).
- `BIG_ENDIAN`, default 1: 1 means byte offset 0 is `[31:24]`; 0 means byte offset 0 is `[7:0]`.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `st_valid`  in  1  store request present.
- `st_ready`  out  1  unit idle and able to accept a request (combinational from state; 0 while `reset` is high).
- `st_addr`  in  32  byte address.
- `st_data`  in  32  register value; the low byte or halfword is used for narrow stores.
- `st_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `st_done`  out  1  one-cycle pulse when the request completes, including on error.
- `st_err`  out  1  one-cycle pulse with `st_done` on a misaligned or illegal request.
- `mem_addr`  out  32  word address (`{st_addr[31:2],2'b00}`), held for the whole operation.
- `mem_rd`  out  1  read strobe, one cycle.
- `mem_rdata`  in  32  read word.
- `mem_wr`  out  1  write strobe, one cycle.
- `mem_wdata`  out  32  merged write word.

## Operation
- States:
  - IDLE: `st_ready`=1.
  - READ: `mem_rd`=1.
  - WAIT: waits READ_LATENCY cycles using a down-counter; `mem_rdata` is captured in the last WAIT cycle.
  - WRITE: `mem_wr`=1 and `st_done`=1.
  - ERR: `st_err`=1 and `st_done`=1.
- Acceptance happens on `st_valid && st_ready`. Address, data and size are registered at that point, so the inputs are don't-care afterwards.
- Transitions from IDLE on acceptance:
  - Illegal request goes to ERR. Illegal means size 11, half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Word store goes to WRITE, with `mem_wdata = st_data`.
  - Byte or half store goes to READ.
- READ→WAIT; WAIT→WRITE when the counter expires; WRITE→IDLE; ERR→IDLE.
- Byte merge: `st_data[7:0]` replaces lane `addr[1:0]`. With BIG_ENDIAN=1, lane k is bits `[31-8k -: 8]`.
- Half merge: `st_data[15:0]` replaces lanes `addr[1]*2` and `addr[1]*2+1`. With BIG_ENDIAN=1, `addr[1]`=0 selects `[31:16]`.
- Unselected bits of the captured word pass through unchanged.
- Error requests never assert `mem_rd` or `mem_wr`.
- `st_valid` while busy is ignored, because `st_ready` is 0. The requester must hold `st_valid` until `st_ready` is seen.

## Timing
- Reset values:
  - state IDLE;
  - `mem_rd`, `mem_wr`, `st_done`, `st_err` all 0;
  - `mem_addr`, `mem_wdata`, captured word all 0.
- All outputs except `st_ready` are registered.
- Accept at cycle T0. Completion cycles:
  - Word: WRITE and `st_done` at T1.
  - Error: ERR at T1.
  - Byte/half: READ at T1, WAIT over T2..T1+L, WRITE and `st_done` at T2+L. With L=1 that is T3.
- Throughput: the next request is accepted in the cycle after WRITE/ERR (back-to-back word stores take one accept every 2 cycles).
- `mem_addr` is valid from T1 through the WRITE cycle.
- Reset asserted mid-operation aborts immediately. No `mem_wr` is issued for the aborted store, and the unit returns to IDLE when reset is released.
- `mem_rdata` is sampled only in the final WAIT cycle; its value in other cycles is ignored.

## Structure
- Shared package `store_pkg`:
  - size constants `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`, `SZ_ILL`;
  - state enum `st_state_t` (IDLE, READ, WAIT, WRITE, ERR).
- Sub-module `store_lane_merge`: purely combinational. Inputs are the old word, `st_data`, size, `addr[1:0]` and BIG_ENDIAN; the output is the merged word. It is reusable by the load path and testable in isolation.
- Top-level contents: FSM, latency counter (width `$clog2(READ_LATENCY+1)`), request registers, output registers.

## Test plan
- Word store, addr 0x100, data 0xDEADBEEF.
  - Required: `mem_wr` at T1 with `mem_addr` 0x100, `mem_wdata` 0xDEADBEEF; `st_done` at T1; `mem_rd` never asserted.
- Byte store, addr 0x103, data 0x000000AA, memory word 0x11223344, L=1.
  - Required: `mem_rd` at T1, `mem_wr` at T3 with 0x112233AA (BE=1); with BE=0, 0xAA223344.
- Half store, addr 0x202, data 0x1234CAFE, memory word 0xFFFFFFFF, L=3.
  - Required: write at T5 with 0xFFFFCAFE (BE=1); `st_ready` low T1–T5 and high at T6.
- Misaligned cases: half at addr 0x101, word at 0x102, size 11.
  - Required for each: `st_err` and `st_done` at T1; no `mem_rd`/`mem_wr`; `mem_wdata` unchanged.
- Reset during WAIT of a byte store.
  - Required: `mem_wr` never asserts, outputs return to reset values, and the next word store completes normally.
- Back-to-back requests.
  - Stimulus: `st_valid` held high with requests word, byte, word.
  - Required: accepts exactly at cycles where `st_ready`=1, each completes once, and input changes during busy cycles are ignored.
